// File: rtl/pci_tx_pkg.sv
// Shared constants for the PCI transmit path: FSM state encoding and FIFO source IDs.
package pci_tx_pkg;

    typedef enum logic [1:0] {
        ST_INIT_WAIT = 2'd0,
        ST_ACTIVE    = 2'd1,
        ST_PAUSED    = 2'd2
    } state_e;

    localparam logic SRC_D0 = 1'b0;
    localparam logic SRC_D1 = 1'b1;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-request round-robin arbiter with one-hot grant and a registered priority pointer.
module rr_arbiter_2
    import pci_tx_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // Pointer names the channel favoured on the next contended cycle.
    logic prio_q;
    logic prio_d;

    always_comb begin
        gnt    = req;
        prio_d = prio_q;
        if (req == 2'b11) begin
            gnt = (prio_q == SRC_D1) ? 2'b10 : 2'b01;
        end
        if (gnt[0]) begin
            prio_d = SRC_D1;
        end else if (gnt[1]) begin
            prio_d = SRC_D0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio_q <= SRC_D0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/d_fifo_drain_reader.sv
// Read-side master draining FIFOs D0/D1 round-robin into one valid-qualified stream.
// Optional per-source delivery counters are built when D_READER_CNT_EN is defined.
module d_fifo_drain_reader
    import pci_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init,
    input  logic                  pause,
    input  logic                  empty_D0,
    input  logic                  empty_D1,
    input  logic [DATA_WIDTH-1:0] data_out_D0,
    input  logic [DATA_WIDTH-1:0] data_out_D1,
    output logic                  rd_enable_D0,
    output logic                  rd_enable_D1,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  source_id,
    output logic                  idle_out,
    output logic [1:0]            state_out
`ifdef D_READER_CNT_EN
    ,
    output logic [7:0]            cnt_D0,
    output logic [7:0]            cnt_D1
`endif
);

    state_e                state_q, state_d;
    logic                  inflight_q, inflight_d;
    logic                  inflight_src_q, inflight_src_d;
    logic                  valid_q, valid_d;
    logic                  src_q, src_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  rd_en;
    logic [1:0]            req;
    logic [1:0]            gnt;

    // init is included so that no pop is issued in the cycle the block is being shut down.
    assign rd_en = (state_q == ST_ACTIVE) & ~pause & init;
    assign req   = {~empty_D1, ~empty_D0} & {2{rd_en}};

    rr_arbiter_2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .gnt   (gnt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_INIT_WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!init) begin
            state_d = ST_INIT_WAIT;
        end else begin
            case (state_q)
                ST_INIT_WAIT: state_d = ST_ACTIVE;
                ST_ACTIVE:    if (pause)  state_d = ST_PAUSED;
                ST_PAUSED:    if (!pause) state_d = ST_ACTIVE;
                default:      state_d = ST_INIT_WAIT;
            endcase
        end
    end

    always_comb begin
        rd_enable_D0 = gnt[0];
        rd_enable_D1 = gnt[1];
        state_out    = state_q;
        idle_out     = (state_q == ST_ACTIVE) & empty_D0 & empty_D1 & ~inflight_q;
        data_out     = data_q;
        valid_out    = valid_q;
        source_id    = src_q;
    end

    // FIFO data lags rd_enable by one cycle, so the pop's source rides one stage ahead of the capture.
    always_comb begin
        inflight_d     = |gnt;
        inflight_src_d = gnt[1] ? SRC_D1 : SRC_D0;
        valid_d        = inflight_q & init;
        data_d         = data_q;
        src_d          = src_q;
        if (valid_d) begin
            data_d = (inflight_src_q == SRC_D1) ? data_out_D1 : data_out_D0;
            src_d  = inflight_src_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight_q     <= 1'b0;
            inflight_src_q <= SRC_D0;
            valid_q        <= 1'b0;
            src_q          <= SRC_D0;
            data_q         <= '0;
        end else begin
            inflight_q     <= inflight_d;
            inflight_src_q <= inflight_src_d;
            valid_q        <= valid_d;
            src_q          <= src_d;
            data_q         <= data_d;
        end
    end

`ifdef D_READER_CNT_EN
    logic [7:0] cnt_D0_q, cnt_D0_d;
    logic [7:0] cnt_D1_q, cnt_D1_d;

    always_comb begin
        cnt_D0_d = cnt_D0_q;
        cnt_D1_d = cnt_D1_q;
        if (state_q == ST_INIT_WAIT) begin
            cnt_D0_d = 8'd0;
            cnt_D1_d = 8'd0;
        end else if (valid_d) begin
            if (src_d == SRC_D1) cnt_D1_d = cnt_D1_q + 8'd1;
            else                 cnt_D0_d = cnt_D0_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_D0_q <= 8'd0;
            cnt_D1_q <= 8'd0;
        end else begin
            cnt_D0_q <= cnt_D0_d;
            cnt_D1_q <= cnt_D1_d;
        end
    end

    assign cnt_D0 = cnt_D0_q;
    assign cnt_D1 = cnt_D1_q;
`endif

endmodule

// File: tb/tb_d_fifo_drain_reader.sv
// Bench for d_fifo_drain_reader: queue-based FIFOs plus a cycle-level reference model.
module tb_d_fifo_drain_reader;

    localparam int DW = 6;

    logic          clk = 1'b0;
    logic          reset, init, pause, empty_D0, empty_D1;
    logic [DW-1:0] data_out_D0, data_out_D1;
    logic          rd_enable_D0, rd_enable_D1, valid_out, source_id, idle_out;
    logic [DW-1:0] data_out;
    logic [1:0]    state_out;
`ifdef D_READER_CNT_EN
    logic [7:0]    cnt_D0, cnt_D1;
`endif

    d_fifo_drain_reader #(.DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .init         (init),
        .pause        (pause),
        .empty_D0     (empty_D0),
        .empty_D1     (empty_D1),
        .data_out_D0  (data_out_D0),
        .data_out_D1  (data_out_D1),
        .rd_enable_D0 (rd_enable_D0),
        .rd_enable_D1 (rd_enable_D1),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .source_id    (source_id),
        .idle_out     (idle_out),
        .state_out    (state_out)
`ifdef D_READER_CNT_EN
        ,
        .cnt_D0       (cnt_D0),
        .cnt_D1       (cnt_D1)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // FIFO contents and observed output stream
    logic [DW-1:0] f0[$], f1[$];
    logic [DW-1:0] obs_d[$];
    bit            obs_s[$];

    // Reference model: mode 0=waiting for init, 1=active, 2=paused
    int            m_state;
    bit            m_prio;
    bit            pend_v, pend_src;
    logic [DW-1:0] pend_d;
    bit            e_v, e_src;
    logic [DW-1:0] e_d;
    int            m_cnt0, m_cnt1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_prio = 0; pend_v = 0; pend_src = 0; pend_d = '0;
        e_v = 0; e_src = 0; e_d = '0; m_cnt0 = 0; m_cnt1 = 0;
    endtask

    // Asynchronous reset pulse between clock edges; outputs must clear at once.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_eq("rst_valid", valid_out, 0);
        check_eq("rst_data", data_out, 0);
        check_eq("rst_src", source_id, 0);
        check_eq("rst_state", state_out, 0);
        check_eq("rst_idle", idle_out, 0);
        check_eq("rst_rd", {rd_enable_D1, rd_enable_D0}, 0);
`ifdef D_READER_CNT_EN
        check_eq("rst_cnt", {cnt_D1, cnt_D0}, 0);
`endif
        #2;
        reset = 1'b0;
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic cycle();
        bit            act, r0, r1, g0, g1, nv;
        int            old_state;
        logic [DW-1:0] w;
        empty_D0 = (f0.size() == 0);
        empty_D1 = (f1.size() == 0);
        #1;
        act = (m_state == 1) && !pause && init;
        r0  = act && (f0.size() != 0);
        r1  = act && (f1.size() != 0);
        g0  = r0 && (!r1 || m_prio == 1'b0);
        g1  = r1 && (!r0 || m_prio == 1'b1);
        check_eq("rd0", rd_enable_D0, g0);
        check_eq("rd1", rd_enable_D1, g1);
        check_eq("rd_both", rd_enable_D0 & rd_enable_D1, 0);
        check_eq("state", state_out, m_state);
        check_eq("valid", valid_out, e_v);
        check_eq("data", data_out, e_d);
        check_eq("src", source_id, e_src);
        check_eq("idle", idle_out, (m_state == 1) && f0.size() == 0 && f1.size() == 0 && !pend_v);
`ifdef D_READER_CNT_EN
        check_eq("cnt0", cnt_D0, m_cnt0);
        check_eq("cnt1", cnt_D1, m_cnt1);
`endif
        if (valid_out === 1'b1) begin
            obs_d.push_back(data_out);
            obs_s.push_back(source_id);
        end
        @(posedge clk);
        #1;
        w = '0;
        if (g0) begin w = f0.pop_front(); data_out_D0 = w; end
        if (g1) begin w = f1.pop_front(); data_out_D1 = w; end
        old_state = m_state;
        nv = pend_v && init;
        if (nv) begin
            e_d = pend_d; e_src = pend_src;
            if (pend_src) m_cnt1 = (m_cnt1 + 1) % 256;
            else          m_cnt0 = (m_cnt0 + 1) % 256;
        end
        e_v = nv;
        if (old_state == 0) begin m_cnt0 = 0; m_cnt1 = 0; end
        pend_v = g0 || g1; pend_src = g1; pend_d = w;
        if (g0) m_prio = 1'b1;
        if (g1) m_prio = 1'b0;
        if (!init)                       m_state = 0;
        else if (m_state == 0)           m_state = 1;
        else if (m_state == 1 && pause)  m_state = 2;
        else if (m_state == 2 && !pause) m_state = 1;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic fresh();
        init = 1'b0; pause = 1'b0;
        f0.delete(); f1.delete(); obs_d.delete(); obs_s.delete();
        do_reset();
    endtask

    initial begin
        reset = 1'b1; init = 1'b0; pause = 1'b0;
        empty_D0 = 1'b1; empty_D1 = 1'b1; data_out_D0 = '0; data_out_D1 = '0;
        model_reset();
        repeat (2) @(negedge clk);

        // 1: D0 alone, three words
        fresh();
        f0 = '{6'h01, 6'h02, 6'h03};
        init = 1'b1;
        run(8);
        check_eq("t1_n", obs_d.size(), 3);
        if (obs_d.size() == 3) begin
            check_eq("t1_w2", obs_d[2], 6'h03);
            check_eq("t1_s0", obs_s[0], 0);
        end

        // 2: both FIFOs filled before init, strict alternation from D0
        fresh();
        f0 = '{6'h0A, 6'h0B};
        f1 = '{6'h11, 6'h12};
        init = 1'b1;
        run(8);
        check_eq("t2_n", obs_d.size(), 4);
        if (obs_d.size() == 4) begin
            check_eq("t2_w0", obs_d[0], 6'h0A);
            check_eq("t2_w1", obs_d[1], 6'h11);
            check_eq("t2_w2", obs_d[2], 6'h0B);
            check_eq("t2_w3", obs_d[3], 6'h12);
        end

        // 3: pause raised the cycle after the second pop
        fresh();
        f0 = '{6'h21, 6'h22, 6'h23, 6'h24};
        init = 1'b1;
        run(3);
        pause = 1'b1;
        run(6);
        check_eq("t3_paused_n", obs_d.size(), 2);
        check_eq("t3_left", f0.size(), 2);
        pause = 1'b0;
        run(6);
        check_eq("t3_final_n", obs_d.size(), 4);

        // 4: init dropped the cycle after a pop
        fresh();
        f0 = '{6'h31, 6'h32, 6'h33};
        init = 1'b1;
        run(2);
        init = 1'b0;
        run(4);
        check_eq("t4_n", obs_d.size(), 0);
        check_eq("t4_left", f0.size(), 2);

        // 5: asynchronous reset mid-stream, D0 favoured afterwards
        fresh();
        for (int i = 0; i < 6; i++) begin
            f0.push_back(DW'(8'h00 + i));
            f1.push_back(DW'(8'h20 + i));
        end
        init = 1'b1;
        run(4);
        do_reset();
        obs_d.delete(); obs_s.delete();
        run(5);
        check_eq("t5_n", obs_d.size() >= 1, 1);
        if (obs_d.size() >= 1) check_eq("t5_first_src", obs_s[0], 0);

        // Randomised traffic, pause, init drops and occasional resets
        fresh();
        for (int i = 0; i < 600; i++) begin
            init  = ($urandom_range(0, 24) != 0);
            pause = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) == 0 && f0.size() < 16) f0.push_back(DW'($urandom));
            if ($urandom_range(0, 2) == 0 && f1.size() < 16) f1.push_back(DW'($urandom));
            if ($urandom_range(0, 149) == 0) do_reset();
            cycle();
        end

`ifdef D_READER_CNT_EN
        // 6: counter wraps at 256
        fresh();
        for (int i = 0; i < 300; i++) f1.push_back(DW'(i));
        init = 1'b1;
        run(310);
        check_eq("t6_cnt1", cnt_D1, 300 % 256);
        check_eq("t6_cnt0", cnt_D0, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
